// File: rtl/pulse_event_fifo.sv
// Pulse edge event FIFO: detects rising/falling edges on 32 filtered channels,
// holds them in per-channel pending bits and serialises them into a show-ahead
// FIFO of timestamped event words {polarity, channel[4:0], timestamp}.
module pulse_event_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            filt_in,
  input  logic                   en,
  output logic [31:0]            evt_data,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   lost,
  input  logic                   clr_lost
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [31:0]     prev_q;
  logic [31:0]     pend_r_q, pend_r_d;
  logic [31:0]     pend_f_q, pend_f_d;
  logic [TS_W-1:0] ts_q;
  logic            lost_q, lost_d;

  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     level_q, level_d;

  logic [31:0]     rise, fall;
  logic            sel_valid, sel_pol;
  logic [4:0]      sel_ch;
  logic            pop, wr, full;
  logic [31:0]     sel_onehot, clr_r, clr_f;
  logic            lost_hit;
  logic [31:0]     wr_word;

  // Edge detection against last cycle's levels
  always_comb begin
    rise = filt_in & ~prev_q;
    fall = ~filt_in & prev_q;
  end

  // Lowest pending channel wins; rising beats falling on the same channel
  always_comb begin
    sel_valid = 1'b0;
    sel_pol   = 1'b0;
    sel_ch    = '0;
    for (int i = 31; i >= 0; i--) begin
      if (pend_r_q[i] || pend_f_q[i]) begin
        sel_valid = 1'b1;
        sel_pol   = pend_r_q[i];
        sel_ch    = 5'(i);
      end
    end
  end

  // Write/pop handshake and pending/lost next state
  always_comb begin
    full       = (level_q == FULL_LEVEL);
    pop        = evt_valid && evt_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    wr         = sel_valid && (!full || pop);
    sel_onehot = 32'd1 << sel_ch;
    clr_r      = (wr && sel_pol)  ? sel_onehot : 32'd0;
    clr_f      = (wr && !sel_pol) ? sel_onehot : 32'd0;
    wr_word    = {sel_pol, sel_ch, ts_q};

    pend_r_d   = (pend_r_q & ~clr_r) | (en ? rise : 32'd0);
    pend_f_d   = (pend_f_q & ~clr_f) | (en ? fall : 32'd0);

    // An edge landing on a still-pending bit of the same polarity merges and is lost
    lost_hit   = en && ((|(rise & pend_r_q & ~clr_r)) || (|(fall & pend_f_q & ~clr_f)));
    if (lost_hit) begin
      lost_d = 1'b1;
    end else if (clr_lost) begin
      lost_d = 1'b0;
    end else begin
      lost_d = lost_q;
    end

    case ({wr, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Edge history, pending bits, timestamp and sticky lost flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      pend_r_q <= '0;
      pend_f_q <= '0;
      ts_q     <= '0;
      lost_q   <= 1'b0;
    end else begin
      prev_q   <= filt_in;
      pend_r_q <= pend_r_d;
      pend_f_q <= pend_f_d;
      ts_q     <= ts_q + 1'b1;
      lost_q   <= lost_d;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Event storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= wr_word;
  end

  assign evt_data  = mem_q[rd_ptr_q];
  assign evt_valid = (level_q != '0);
  assign level     = level_q;
  assign lost      = lost_q;

endmodule

// File: tb/tb_pulse_event_fifo.sv
// Randomised and directed bench for pulse_event_fifo against a queue-based model.
module tb_pulse_event_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] filt_in = '0;
  logic        en = 1'b0;
  logic        evt_ready = 1'b0;
  logic        clr_lost = 1'b0;
  logic [31:0] evt_data;
  logic        evt_valid;
  logic [4:0]  level;
  logic        lost;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  bit [31:0]   m_prev, m_pr, m_pf;
  int unsigned m_ts;
  bit          m_lost;
  int unsigned m_q[$];

  logic [31:0] cur;

  pulse_event_fifo #(.DEPTH(DEPTH), .TS_W(26)) dut (
    .clk       (clk),
    .rst       (rst),
    .filt_in   (filt_in),
    .en        (en),
    .evt_data  (evt_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .level     (level),
    .lost      (lost),
    .clr_lost  (clr_lost)
  );

  always #25 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = '0;
    m_pr   = '0;
    m_pf   = '0;
    m_ts   = 0;
    m_lost = 1'b0;
    m_q.delete();
  endtask

  // One clock of the model, using inputs as seen at the rising edge
  task automatic model_step();
    bit          pop, wr, pol, lost_now;
    int          ch;
    int unsigned w, dummy;
    pop = (m_q.size() != 0) && evt_ready;
    ch  = -1;
    for (int i = 0; i < 32; i++) if (ch < 0 && (m_pr[i] || m_pf[i])) ch = i;
    wr = (ch >= 0) && ((m_q.size() < DEPTH) || pop);
    if (pop) dummy = m_q.pop_front();
    if (wr) begin
      pol = m_pr[ch];
      w   = (int'(ch) << 26) + m_ts;
      if (pol) w = w + 32'h8000_0000;
      m_q.push_back(w);
      if (pol) m_pr[ch] = 1'b0;
      else     m_pf[ch] = 1'b0;
    end
    lost_now = 1'b0;
    if (en) begin
      for (int i = 0; i < 32; i++) begin
        if (filt_in[i] && !m_prev[i]) begin
          if (m_pr[i]) lost_now = 1'b1;
          m_pr[i] = 1'b1;
        end
        if (!filt_in[i] && m_prev[i]) begin
          if (m_pf[i]) lost_now = 1'b1;
          m_pf[i] = 1'b1;
        end
      end
    end
    if (lost_now) m_lost = 1'b1;
    else if (clr_lost) m_lost = 1'b0;
    m_prev = filt_in;
    m_ts   = (m_ts + 1) % (1 << 26);
  endtask

  // Entered at a falling edge; returns at the next falling edge
  task automatic cyc(input logic [31:0] f, input logic e, input logic r, input logic c);
    filt_in   = f;
    en        = e;
    evt_ready = r;
    clr_lost  = c;
    @(posedge clk);
    model_step();
    #1;
    check("valid", 32'(evt_valid), 32'(m_q.size() != 0));
    check("level", 32'(level), m_q.size());
    check("lost", 32'(lost), 32'(m_lost));
    if (m_q.size() != 0) check("data", evt_data, m_q[0]);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_level", 32'(level), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_lost", 32'(lost), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (m_q.size() == 0 && m_pr == 0 && m_pf == 0) break;
      cyc(cur, 1'b1, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(evt_valid), 0);
  endtask

  task automatic set_ts(input logic [25:0] v);
    force dut.ts_q = v;
    #1;
    release dut.ts_q;
    m_ts = v;
  endtask

  initial begin
    cur = '0;
    @(negedge clk);
    do_reset();

    // Single rise on channel 5
    for (int i = 0; i < 10; i++) cyc(cur, 1'b1, 1'b0, 1'b0);
    cur[5] = 1'b1;
    cyc(cur, 1'b1, 1'b0, 1'b0);
    cyc(cur, 1'b1, 1'b0, 1'b0);
    check("rise_valid", 32'(evt_valid), 1);
    check("rise_hdr", 32'(evt_data[31:26]), 32'h25);
    drain();

    // Simultaneous ch3 rise and ch1 fall: ch1 fall served first
    cur[1] = 1'b1;
    cyc(cur, 1'b1, 1'b1, 1'b0);
    drain();
    cur[1] = 1'b0;
    cur[3] = 1'b1;
    for (int i = 0; i < 4; i++) cyc(cur, 1'b1, 1'b0, 1'b0);
    check("simul_first", 32'(evt_data[31:26]), 32'h01);
    cyc(cur, 1'b1, 1'b1, 1'b0);
    check("simul_second", 32'(evt_data[31:26]), 32'h23);
    drain();

    // Backpressure: 20 channels toggle into a 16-deep FIFO
    cur = cur ^ 32'h000F_FFFF;
    for (int i = 0; i < 22; i++) cyc(cur, 1'b1, 1'b0, 1'b0);
    check("full_level", 32'(level), 16);
    check("full_lost", 32'(lost), 0);
    drain();

    // Lost: ch7 rise, fall, rise while FIFO full
    cur[7] = 1'b0;
    cyc(cur, 1'b1, 1'b1, 1'b0);
    drain();
    cur = cur ^ 32'hFFFF_FF00;
    for (int i = 0; i < 18; i++) cyc(cur, 1'b1, 1'b0, 1'b0);
    cur[7] = 1'b1; cyc(cur, 1'b1, 1'b0, 1'b0);
    cur[7] = 1'b0; cyc(cur, 1'b1, 1'b0, 1'b0);
    cur[7] = 1'b1; cyc(cur, 1'b1, 1'b0, 1'b0);
    check("lost_set", 32'(lost), 1);
    cyc(cur, 1'b1, 1'b0, 1'b1);
    check("lost_clr", 32'(lost), 0);
    drain();

    // Timestamp wrap
    set_ts(26'h3FF_FFFE);
    cur = cur ^ 32'h0000_0014;
    cyc(cur, 1'b1, 1'b0, 1'b0);
    cyc(cur, 1'b1, 1'b0, 1'b0);
    cyc(cur, 1'b1, 1'b0, 1'b0);
    check("wrap_hi", 32'(evt_data[25:0]), 32'h03FF_FFFF);
    cyc(cur, 1'b1, 1'b1, 1'b0);
    check("wrap_lo", 32'(evt_data[25:0]), 0);
    drain();

    // en=0 while ch0 toggles
    for (int i = 0; i < 6; i++) begin
      cur[0] = ~cur[0];
      cyc(cur, 1'b0, 1'b1, 1'b0);
    end
    check("en0_valid", 32'(evt_valid), 0);

    // Reset with 5 queued events
    cur = cur ^ 32'h0000_7C00;
    for (int i = 0; i < 7; i++) cyc(cur, 1'b1, 1'b0, 1'b0);
    check("q5_level", 32'(level), 5);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(cur, 1'b1, 1'b0, 1'b0);
    drain();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cur = cur ^ ($urandom & $urandom & $urandom);
      cyc(cur, ($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 9) == 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_event_fifo.md
PULSE_EVENT_FIFO -- requirements
Module: pulse_event_fifo

Interface
REQ-001 Parameter DEPTH, default 16, event FIFO depth in entries; power of two, 4 to 64.
REQ-002 Parameter TS_W, default 26, timestamp width in bits; fixed so the event word is 32 bits.
REQ-003 Port clk, input, 1, 20 MHz system clock; all logic on its rising edge.
REQ-004 Port rst, input, 1, asynchronous reset, active-high.
REQ-005 Port filt_in, input, 32, filtered pulse levels from the 32-channel pulse filter, synchronous to clk.
REQ-006 Port en, input, 1, edge-capture enable.
REQ-007 Port evt_data, output, 32, head event word: [31] polarity (1 = rising), [30:26] channel, [25:0] timestamp.
REQ-008 Port evt_valid, output, 1, FIFO holds at least one event.
REQ-009 Port evt_ready, input, 1, consumer accepts the head event.
REQ-010 Port level, output, clog2(DEPTH)+1, current FIFO occupancy.
REQ-011 Port lost, output, 1, sticky flag: at least one edge dropped.
REQ-012 Port clr_lost, input, 1, single-cycle clear of lost.

Function
REQ-013 prev register holds filt_in from the previous cycle; rise = filt_in & ~prev, fall = ~filt_in & prev, per channel.
REQ-014 prev updates every cycle regardless of en; with en=0, rise/fall are ignored and no pending bit is set.
REQ-015 Pending registers pend_r[31:0] and pend_f[31:0]: a bit is set in the cycle its edge is detected (en=1).
REQ-016 Timestamp counter, TS_W bits, increments every cycle, wraps from all-ones to 0.
REQ-017 Selector: lowest channel index with pend_r or pend_f set; if both are set for that channel, rising is served first.
REQ-018 When a selection exists and the FIFO is not full, or full with a pop in the same cycle, the selected event is written and its pending bit is cleared in that cycle; at most one write per cycle.
REQ-019 Event timestamp = counter value in the write cycle; channel = selected index; polarity = 1 for pend_r, 0 for pend_f.
REQ-020 Latency: edge sampled at clock k sets pending at k; with the FIFO empty and no other pending, the event is written at k+1 and evt_valid is high after k+1.
REQ-021 FIFO is show-ahead: evt_data is the head entry whenever evt_valid=1; evt_valid = (level != 0).
REQ-022 Pop occurs when evt_valid & evt_ready; evt_ready while empty is ignored.
REQ-023 Simultaneous write and pop: level unchanged; when full this is permitted and nothing is dropped.
REQ-024 Pointers wrap modulo DEPTH; level saturates at neither bound and never exceeds DEPTH.
REQ-025 FIFO full: pending bits are held, not dropped; they drain when space frees.
REQ-026 Lost condition: a new edge on a channel whose same-polarity pending bit is set and not being cleared in that cycle; lost is set and the new edge merges into the existing pending bit.
REQ-027 An edge arriving in the same cycle its pending bit is cleared re-sets the bit, and lost is not set.
REQ-028 clr_lost clears lost on the next clock; a lost set in the same cycle wins over clr_lost.
REQ-029 en deasserted mid-operation does not stop draining of pending bits or FIFO pops.

Reset
REQ-030 While rst=1: prev=0, pend_r=pend_f=0, timestamp=0, FIFO pointers and level=0, evt_valid=0, lost=0; evt_data is don't-care.
REQ-031 Reset mid-operation discards all pending and queued events; after release, a channel already high in filt_in produces a rising event, because prev=0.

Verification
REQ-032 Single rise: with en=1, filt_in[5] goes 0->1 at cycle 10 after reset -> one event with bit31=1, channel=5, timestamp=11, evt_valid high from cycle 12.
REQ-033 Simultaneous edges: channels 3 (rise) and 1 (fall) in the same cycle -> events for ch1 fall then ch3 rise on consecutive write cycles, timestamps differing by 1.
REQ-034 Full/backpressure: DEPTH=16, evt_ready=0, toggle 20 distinct channels -> level=16, 4 pending held, lost=0; raise evt_ready -> all 20 events delivered in channel order.
REQ-035 Lost: FIFO full, ch7 rises, falls, and rises again before it is served -> lost=1, one pend_r and one pend_f for ch7 delivered; clr_lost -> lost=0.
REQ-036 Timestamp wrap: force the counter near 2^26-1 -> event timestamps go 0x3FFFFFF then 0x0000000.
REQ-037 en/reset: en=0 while ch0 toggles -> no events; assert rst with 5 queued -> level=0 and evt_valid=0 on the same cycle.
